// File: rtl/id_ex_stage_reg_if.sv
// ============================================================================
// Module      : id_ex_stage_reg_if
// Description : ID/EX pipeline register bundle: decoded ID fields in, EX-stage
//               copies, hazard stall and bubble counter out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_ex_stage_reg_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    logic                  stall;
    logic                  flush;
    logic                  id_valid;
    logic [DATA_WIDTH-1:0] id_pc;
    logic [DATA_WIDTH-1:0] id_rs1_data;
    logic [DATA_WIDTH-1:0] id_rs2_data;
    logic [DATA_WIDTH-1:0] id_imm;
    logic [ADDR_WIDTH-1:0] id_rs1;
    logic [ADDR_WIDTH-1:0] id_rs2;
    logic [ADDR_WIDTH-1:0] id_rd;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [2:0]            id_funct3;
    logic [6:0]            id_funct7;
    logic [1:0]            id_alu_op;
    logic [5:0]            id_ctrl;

    logic                  ex_valid;
    logic [DATA_WIDTH-1:0] ex_pc;
    logic [DATA_WIDTH-1:0] ex_rs1_data;
    logic [DATA_WIDTH-1:0] ex_rs2_data;
    logic [DATA_WIDTH-1:0] ex_imm;
    logic [ADDR_WIDTH-1:0] ex_rs1;
    logic [ADDR_WIDTH-1:0] ex_rs2;
    logic [ADDR_WIDTH-1:0] ex_rd;
    logic [2:0]            ex_funct3;
    logic [6:0]            ex_funct7;
    logic [1:0]            ex_alu_op;
    logic [5:0]            ex_ctrl;
    logic                  load_use_stall;
    logic [CNT_WIDTH-1:0]  bubble_count;

    modport master (
        output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_funct3,
               id_funct7, id_alu_op, id_ctrl,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1,
               ex_rs2, ex_rd, ex_funct3, ex_funct7, ex_alu_op, ex_ctrl,
               load_use_stall, bubble_count
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_funct3,
               id_funct7, id_alu_op, id_ctrl,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1,
               ex_rs2, ex_rd, ex_funct3, ex_funct7, ex_alu_op, ex_ctrl,
               load_use_stall, bubble_count
    );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
// ============================================================================
// Module      : id_ex_stage_reg
// Description : RV32I decode-to-execute pipeline register with load-use hazard
//               detection, bubble insertion, stall/flush and bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    id_ex_stage_reg_if.slave     bus
);
    localparam int c_MEM_READ_BIT = 4;

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_rs1_data;
    logic [DATA_WIDTH-1:0] r_rs2_data;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [ADDR_WIDTH-1:0] r_rs1;
    logic [ADDR_WIDTH-1:0] r_rs2;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [2:0]            r_funct3;
    logic [6:0]            r_funct7;
    logic [1:0]            r_alu_op;
    logic [5:0]            r_ctrl;
    logic [CNT_WIDTH-1:0]  r_bubble_count;

    logic w_hz;
    logic w_bubble;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // A load in EX whose destination is read by ID cannot forward in time.
    assign w_rs1_hit = bus.id_use_rs1 && (bus.id_rs1 == r_rd);
    assign w_rs2_hit = bus.id_use_rs2 && (bus.id_rs2 == r_rd);
    assign w_hz      = r_valid && r_ctrl[c_MEM_READ_BIT] && (r_rd != '0) &&
                       bus.id_valid && (w_rs1_hit || w_rs2_hit);

    // Flush beats stall; a hazard only inserts a bubble when not stalled.
    assign w_bubble  = bus.flush || (!bus.stall && w_hz);

    always_ff @(posedge clk) begin
        if (!rst_n || w_bubble) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_funct3   <= '0;
            r_funct7   <= '0;
            r_alu_op   <= '0;
            r_ctrl     <= '0;
        end else if (!bus.stall) begin
            r_valid    <= bus.id_valid;
            r_pc       <= bus.id_pc;
            r_rs1_data <= bus.id_rs1_data;
            r_rs2_data <= bus.id_rs2_data;
            r_imm      <= bus.id_imm;
            r_rs1      <= bus.id_rs1;
            r_rs2      <= bus.id_rs2;
            r_rd       <= bus.id_rd;
            r_funct3   <= bus.id_funct3;
            r_funct7   <= bus.id_funct7;
            r_alu_op   <= bus.id_alu_op;
            r_ctrl     <= bus.id_valid ? bus.id_ctrl : 6'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bubble_count <= '0;
        end else if (w_bubble && (r_bubble_count != '1)) begin
            r_bubble_count <= r_bubble_count + CNT_WIDTH'(1);
        end
    end

    assign bus.ex_valid       = r_valid;
    assign bus.ex_pc          = r_pc;
    assign bus.ex_rs1_data    = r_rs1_data;
    assign bus.ex_rs2_data    = r_rs2_data;
    assign bus.ex_imm         = r_imm;
    assign bus.ex_rs1         = r_rs1;
    assign bus.ex_rs2         = r_rs2;
    assign bus.ex_rd          = r_rd;
    assign bus.ex_funct3      = r_funct3;
    assign bus.ex_funct7      = r_funct7;
    assign bus.ex_alu_op      = r_alu_op;
    assign bus.ex_ctrl        = r_ctrl;
    assign bus.load_use_stall = w_hz && !bus.flush && !bus.stall;
    assign bus.bubble_count   = r_bubble_count;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
// ============================================================================
// Module      : tb_id_ex_stage_reg
// Description : Scoreboard bench for id_ex_stage_reg (16-bit and 4-bit counter).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) bus ();
    id_ex_stage_reg_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4))  bus2 ();

    id_ex_stage_reg #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    id_ex_stage_reg #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4)) dut2 (
        .clk(clk), .rst_n(rst2_n), .bus(bus2));

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        use1, use2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [1:0]  aluop;
        logic [5:0]  ctrl;
    } id_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [1:0]  aluop;
        logic [5:0]  ctrl;
    } ex_t;

    typedef struct {
        string       name;
        logic        lus;
        ex_t         ex;
        logic [15:0] cnt;
    } rec_t;

    rec_t       q[$];
    logic [3:0] q2[$];

    function automatic id_t mk_id(input logic v, input logic [31:0] pc, rs1d, rs2d, imm,
                                  input logic [4:0] rs1, rs2, rd, input logic u1, u2,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [1:0] aop, input logic [5:0] ctrl);
        id_t r;
        r.valid = v;  r.pc = pc;   r.rs1d = rs1d; r.rs2d = rs2d; r.imm = imm;
        r.rs1 = rs1;  r.rs2 = rs2; r.rd = rd;     r.use1 = u1;   r.use2 = u2;
        r.f3 = f3;    r.f7 = f7;   r.aluop = aop; r.ctrl = ctrl;
        return r;
    endfunction

    // An ID instruction as it must look once it has entered EX.
    function automatic ex_t to_ex(input id_t i);
        ex_t e;
        e.valid = i.valid; e.pc = i.pc; e.rs1d = i.rs1d; e.rs2d = i.rs2d; e.imm = i.imm;
        e.rs1 = i.rs1; e.rs2 = i.rs2; e.rd = i.rd; e.f3 = i.f3; e.f7 = i.f7;
        e.aluop = i.aluop; e.ctrl = i.valid ? i.ctrl : 6'b0;
        return e;
    endfunction

    function automatic ex_t dut_ex();
        ex_t e;
        e.valid = bus.ex_valid; e.pc = bus.ex_pc; e.rs1d = bus.ex_rs1_data;
        e.rs2d = bus.ex_rs2_data; e.imm = bus.ex_imm; e.rs1 = bus.ex_rs1;
        e.rs2 = bus.ex_rs2; e.rd = bus.ex_rd; e.f3 = bus.ex_funct3;
        e.f7 = bus.ex_funct7; e.aluop = bus.ex_alu_op; e.ctrl = bus.ex_ctrl;
        return e;
    endfunction

    task automatic step(input string name, input id_t id, input logic rst, stl, fl,
                        input logic exp_lus, input ex_t exp_ex, input logic [15:0] exp_cnt);
        rec_t r;
        rst_n           = rst;
        bus.stall       = stl;
        bus.flush       = fl;
        bus.id_valid    = id.valid;
        bus.id_pc       = id.pc;
        bus.id_rs1_data = id.rs1d;
        bus.id_rs2_data = id.rs2d;
        bus.id_imm      = id.imm;
        bus.id_rs1      = id.rs1;
        bus.id_rs2      = id.rs2;
        bus.id_rd       = id.rd;
        bus.id_use_rs1  = id.use1;
        bus.id_use_rs2  = id.use2;
        bus.id_funct3   = id.f3;
        bus.id_funct7   = id.f7;
        bus.id_alu_op   = id.aluop;
        bus.id_ctrl     = id.ctrl;
        r.name = name; r.lus = exp_lus; r.ex = exp_ex; r.cnt = exp_cnt;
        q.push_back(r);
        @(posedge clk);
        #2;
    endtask

    // Monitor: load_use_stall mid-cycle, then EX contents just after the edge.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                r = q.pop_front();
                n_tests++;
                if (bus.load_use_stall !== r.lus) begin
                    n_fail++;
                    $display("FAIL %s load_use_stall: got %b expected %b", r.name, bus.load_use_stall, r.lus);
                end
                @(posedge clk);
                #1;
                n_tests++;
                if (dut_ex() !== r.ex) begin
                    n_fail++;
                    $display("FAIL %s ex state: got %h expected %h", r.name, dut_ex(), r.ex);
                end
                n_tests++;
                if (bus.bubble_count !== r.cnt) begin
                    n_fail++;
                    $display("FAIL %s bubble_count: got %0d expected %0d", r.name, bus.bubble_count, r.cnt);
                end
            end
        end
    end

    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (q2.size() > 0) begin
                e = q2.pop_front();
                @(posedge clk);
                #1;
                n_tests++;
                if (bus2.bubble_count !== e || bus2.ex_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sat bubble_count: got %0d valid %b expected %0d valid 0",
                             bus2.bubble_count, bus2.ex_valid, e);
                end
            end
        end
    end

    initial begin
        id_t i_full, i_add0, i_lw, i_add3, i_lw0, i_add00, i_lw5, i_add55, i_inv;
        ex_t bub;
        bub     = '0;
        i_full  = mk_id(1, 32'hFFC, 32'hAAAA5555, 32'h12345678, 32'hFFFFFFF0, 1, 2, 9, 1, 1, 3'd7, 7'h7F, 2'b11, 6'h3F);
        i_add0  = mk_id(1, 32'h100, 5, 7, 0, 1, 2, 4, 1, 1, 3'd0, 7'h20, 2'b10, 6'b000100);
        i_lw    = mk_id(1, 32'h104, 32'h1000, 0, 8, 1, 0, 3, 1, 0, 3'd2, 7'h00, 2'b00, 6'b110110);
        i_add3  = mk_id(1, 32'h108, 32'h11, 32'h22, 0, 5, 3, 6, 1, 1, 3'd0, 7'h00, 2'b10, 6'b000100);
        i_lw0   = mk_id(1, 32'h10C, 32'h2000, 0, 4, 2, 0, 0, 1, 0, 3'd2, 7'h00, 2'b00, 6'b110110);
        i_add00 = mk_id(1, 32'h110, 0, 0, 0, 0, 0, 7, 1, 1, 3'd0, 7'h00, 2'b10, 6'b000100);
        i_lw5   = mk_id(1, 32'h114, 32'h3000, 0, 12, 1, 0, 5, 1, 0, 3'd2, 7'h00, 2'b00, 6'b110110);
        i_add55 = mk_id(1, 32'h118, 32'h33, 32'h44, 0, 5, 5, 8, 1, 1, 3'd0, 7'h00, 2'b10, 6'b000100);
        i_inv   = mk_id(0, 32'h200, 9, 10, 11, 5, 3, 10, 1, 1, 3'd1, 7'h01, 2'b10, 6'h3F);

        bus2.stall = 1'b0; bus2.flush = 1'b0; bus2.id_valid = 1'b0; bus2.id_pc = '0;
        bus2.id_rs1_data = '0; bus2.id_rs2_data = '0; bus2.id_imm = '0; bus2.id_rs1 = '0;
        bus2.id_rs2 = '0; bus2.id_rd = '0; bus2.id_use_rs1 = 1'b0; bus2.id_use_rs2 = 1'b0;
        bus2.id_funct3 = '0; bus2.id_funct7 = '0; bus2.id_alu_op = '0; bus2.id_ctrl = '0;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.id_valid = 1'b0;

        @(posedge clk);
        #2;
        //    name         id       rst stl fl  lus  expected EX      cnt
        step("rst_a",      i_full,  0,  0,  0,  0,   bub,             0);
        step("rst_b",      i_full,  0,  0,  0,  0,   bub,             0);
        step("pass_add",   i_add0,  1,  0,  0,  0,   to_ex(i_add0),   0);
        step("lw_x3",      i_lw,    1,  0,  0,  0,   to_ex(i_lw),     0);
        step("lu_hazard",  i_add3,  1,  0,  0,  1,   bub,             1);
        step("lu_advance", i_add3,  1,  0,  0,  0,   to_ex(i_add3),   1);
        step("lw_x0",      i_lw0,   1,  0,  0,  0,   to_ex(i_lw0),    1);
        step("x0_nohz",    i_add00, 1,  0,  0,  0,   to_ex(i_add00),  1);
        step("lw_x5",      i_lw5,   1,  0,  0,  0,   to_ex(i_lw5),    1);
        step("both_hit",   i_add55, 1,  0,  0,  1,   bub,             2);
        step("both_adv",   i_add55, 1,  0,  0,  0,   to_ex(i_add55),  2);
        step("lw_x5_b",    i_lw5,   1,  0,  0,  0,   to_ex(i_lw5),    2);
        step("flush_stl",  i_add55, 1,  1,  1,  0,   bub,             3);
        step("pre_stall",  i_add0,  1,  0,  0,  0,   to_ex(i_add0),   3);
        step("stall_1",    i_lw,    1,  1,  0,  0,   to_ex(i_add0),   3);
        step("stall_2",    i_add3,  1,  1,  0,  0,   to_ex(i_add0),   3);
        step("stall_3",    i_full,  1,  1,  0,  0,   to_ex(i_add0),   3);
        step("invalid_id", i_inv,   1,  0,  0,  0,   to_ex(i_inv),    3);
        step("rst_in_stl", i_full,  0,  1,  0,  0,   bub,             0);
        step("post_rst",   i_full,  1,  0,  0,  0,   to_ex(i_full),   0);
        step("after_full", i_add0,  1,  0,  0,  0,   to_ex(i_add0),   0);

        rst2_n = 1'b0;
        q2.push_back(4'd0);
        @(posedge clk);
        #2;
        rst2_n     = 1'b1;
        bus2.flush = 1'b1;
        for (int k = 0; k < 20; k++) begin
            q2.push_back((k + 1 > 15) ? 4'd15 : 4'(k + 1));
            @(posedge clk);
            #2;
        end
        bus2.flush = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (q.size() != 0 || q2.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q.size(), q2.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
